// File: rtl/arb_rr_lock.sv
// Round-robin arbiter with packet lock: multicast class dominates unicast, a grant is held
// until the tail flit moves or the granted request drops, then a one-cycle bubble follows.
module arb_rr_lock #(
    parameter int unsigned NPORT = 5
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [NPORT-1:0] u_req,
    input  logic [NPORT-1:0] m_req,
    input  logic [NPORT-1:0] multab_ct,
    input  logic             xfer,
    input  logic [NPORT-1:0] tail,
    output logic [NPORT-1:0] grt,
    output logic             grt_mc,
    output logic             busy
);

    localparam int unsigned PTR_W = $clog2(NPORT);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_m_q, ptr_m_d;
    logic [PTR_W-1:0]   ptr_u_q, ptr_u_d;
    logic [NPORT-1:0]   grt_q, grt_d;
    logic               grt_mc_q, grt_mc_d;

    // First set bit at or above ptr, wrapping modulo NPORT. MSB of the result flags a hit.
    function automatic logic [PTR_W:0] pick(input logic [NPORT-1:0] vec,
                                            input logic [PTR_W-1:0] ptr);
        logic [PTR_W:0] res;
        int unsigned    idx;
        res = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            idx = (32'(ptr) + i) % NPORT;
            if (!res[PTR_W] && vec[idx]) begin
                res = {1'b1, PTR_W'(idx)};
            end
        end
        return res;
    endfunction

    logic [NPORT-1:0] e_m;
    logic             mc_sel;
    logic [PTR_W:0]   win;
    logic [PTR_W-1:0] own;
    logic [PTR_W-1:0] own_nxt;
    logic             own_req;
    logic             release_now;

    always_comb begin
        own = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            if (grt_q[i]) begin
                own = PTR_W'(i);
            end
        end
    end

    always_comb begin
        e_m         = m_req & ~multab_ct;
        mc_sel      = |m_req;
        win         = mc_sel ? pick(e_m, ptr_m_q) : pick(u_req, ptr_u_q);
        own_nxt     = (own == PTR_W'(NPORT - 1)) ? '0 : own + 1'b1;
        own_req     = grt_mc_q ? m_req[own] : u_req[own];
        release_now = (xfer && tail[own]) || !own_req;

        state_d  = state_q;
        ptr_m_d  = ptr_m_q;
        ptr_u_d  = ptr_u_q;
        grt_d    = grt_q;
        grt_mc_d = grt_mc_q;

        unique case (state_q)
            StIdle: begin
                // xfer is meaningless without an owner and is deliberately not looked at here
                if (win[PTR_W]) begin
                    state_d  = StLocked;
                    grt_d    = NPORT'(1) << win[PTR_W-1:0];
                    grt_mc_d = mc_sel;
                end
            end
            StLocked: begin
                if (release_now) begin
                    state_d  = StIdle;
                    grt_d    = '0;
                    grt_mc_d = 1'b0;
                    if (grt_mc_q) begin
                        ptr_m_d = own_nxt;
                    end else begin
                        ptr_u_d = own_nxt;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= StIdle;
            ptr_m_q  <= '0;
            ptr_u_q  <= '0;
            grt_q    <= '0;
            grt_mc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_m_q  <= ptr_m_d;
            ptr_u_q  <= ptr_u_d;
            grt_q    <= grt_d;
            grt_mc_q <= grt_mc_d;
        end
    end

    assign grt    = grt_q;
    assign grt_mc = grt_mc_q;
    assign busy   = (state_q == StLocked);

endmodule
